// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button conditioning stage.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        PRESSED      = 2'b10,
        RELEASE_WAIT = 2'b11
    } btn_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
    localparam int unsigned DEF_REPEAT_DELAY    = 5000000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 2500000;

    // Smallest counter width w with 2**w strictly greater than every count limit.
    function automatic int unsigned min_cnt_w(
        input int unsigned debounce,
        input int unsigned rdelay,
        input int unsigned rperiod
    );
        int unsigned m;
        m = debounce;
        if (rdelay > m) m = rdelay;
        if (rperiod > m) m = rperiod;
        if (m == 0) return 1;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-low reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_step_debouncer.sv
// Debounces the raw button into a clean level and a one-cycle step pulse.
// Optional auto-repeat while held is built when BTN_AUTO_REPEAT_EN is defined.
module btn_step_debouncer
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic step_pulse,
    output logic btn_level
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s;
    btn_state_t       state;
    btn_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;
    logic             press_fire;
    logic             rep_fire;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_raw),
        .q     (s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            btn_level  <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            btn_level  <= level_nxt;
            step_pulse <= press_fire | rep_fire;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        level_nxt  = btn_level;
        press_fire = 1'b0;
        case (state)
            IDLE: begin
                level_nxt = 1'b0;
                if (s) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt  = PRESSED;
                    cnt_nxt    = '0;
                    level_nxt  = 1'b1;
                    press_fire = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                level_nxt = 1'b1;
                if (!s) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                level_nxt = 1'b0;
            end
        endcase
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rcnt;
    logic [CNT_W-1:0] rcnt_nxt;
    logic             rphase;
    logic             rphase_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt   <= '0;
            rphase <= 1'b0;
        end else begin
            rcnt   <= rcnt_nxt;
            rphase <= rphase_nxt;
        end
    end

    // rphase selects the initial delay (0) or the steady repeat period (1);
    // RELEASE_WAIT leaves both untouched so a bounce resumes the count.
    always_comb begin
        rcnt_nxt   = rcnt;
        rphase_nxt = rphase;
        rep_fire   = 1'b0;
        if (press_fire) begin
            rcnt_nxt   = '0;
            rphase_nxt = 1'b0;
        end else if (state == PRESSED && state_nxt == PRESSED) begin
            if (rcnt == (rphase ? PER_LAST : DLY_LAST)) begin
                rep_fire   = 1'b1;
                rcnt_nxt   = '0;
                rphase_nxt = 1'b1;
            end else begin
                rcnt_nxt = rcnt + CNT_W'(1);
            end
        end else if (state_nxt == IDLE) begin
            rcnt_nxt   = '0;
            rphase_nxt = 1'b0;
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (REPEAT_DELAY != 0) ^ (REPEAT_PERIOD != 0);
    assign rep_fire          = 1'b0;
`endif

endmodule

// File: tb/tb_btn_step_debouncer.sv
// Directed self-checking bench for btn_step_debouncer (DEBOUNCE_CYCLES=4, plus a DEBOUNCE_CYCLES=1 instance).
module tb_btn_step_debouncer;

    localparam int unsigned TB_CNT_W = btn_pkg::min_cnt_w(4, 10, 5);

    logic clk = 1'b0;
    logic rst_n;
    logic btn_raw;
    logic step_pulse;
    logic btn_level;
    logic step_pulse_d1;
    logic btn_level_d1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic  rst;
        logic  raw;
        logic  pulse;
        logic  level;
        string tag;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    btn_step_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (TB_CNT_W),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .step_pulse (step_pulse),
        .btn_level  (btn_level)
    );

    btn_step_debouncer #(
        .DEBOUNCE_CYCLES (1),
        .CNT_W           (TB_CNT_W),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5)
    ) dut_d1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .step_pulse (step_pulse_d1),
        .btn_level  (btn_level_d1)
    );

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic void add_n(input int n, input logic r, input logic b,
                                  input logic p, input logic l, input string tag);
        vec_t v;
        v.rst = r; v.raw = b; v.pulse = p; v.level = l; v.tag = tag;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    // Inputs change on the falling edge; outputs are sampled one falling edge later.
    task automatic step(input logic r, input logic b);
        rst_n   = r;
        btn_raw = b;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   pulses;
        int   idx;
        int   consec;
        logic prev;
        int   first;
        int   nrep;
        int   offs[$];

        rst_n   = 1'b0;
        btn_raw = 1'b0;

        add_n(3, 0, 0, 0, 0, "reset");
        // clean press then clean release
        add_n(6, 1, 1, 0, 0, "a_wait");
        add_n(1, 1, 1, 1, 1, "a_pulse");
        add_n(5, 1, 1, 0, 1, "a_held");
        add_n(6, 1, 0, 0, 1, "a_relwait");
        add_n(4, 1, 0, 0, 0, "a_idle");
        // press bounce 1,1,0,1,0,1,1 then held high
        add_n(2, 1, 1, 0, 0, "b_bounce");
        add_n(1, 1, 0, 0, 0, "b_bounce");
        add_n(1, 1, 1, 0, 0, "b_bounce");
        add_n(1, 1, 0, 0, 0, "b_bounce");
        add_n(2, 1, 1, 0, 0, "b_bounce");
        add_n(4, 1, 1, 0, 0, "b_wait");
        add_n(1, 1, 1, 1, 1, "b_pulse");
        add_n(3, 1, 1, 0, 1, "b_held");
        // release bounce 0,0,1 then low
        add_n(2, 1, 0, 0, 1, "c_bounce");
        add_n(1, 1, 1, 0, 1, "c_bounce");
        add_n(6, 1, 0, 0, 1, "c_relwait");
        add_n(4, 1, 0, 0, 0, "c_idle");
        // reset while PRESS_WAIT holds cnt=2, then full re-debounce
        add_n(5, 1, 1, 0, 0, "d_count");
        add_n(2, 0, 1, 0, 0, "d_reset");
        add_n(6, 1, 1, 0, 0, "d_wait");
        add_n(1, 1, 1, 1, 1, "d_pulse");
        add_n(2, 1, 1, 0, 1, "d_held");

        @(negedge clk);
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].raw);
            check_bit($sformatf("%s[%0d].pulse", vecs[i].tag, i), step_pulse, vecs[i].pulse);
            check_bit($sformatf("%s[%0d].level", vecs[i].tag, i), btn_level, vecs[i].level);
        end

        // asynchronous reset clears the level without waiting for a clock edge
        rst_n = 1'b0;
        #1;
        check_bit("reset_async_level", btn_level, 1'b0);
        check_bit("reset_async_pulse", step_pulse, 1'b0);
        @(negedge clk);
        step(0, 0);

        pulses = 0; idx = 0; consec = 0; prev = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 20; c++) begin
                step(1, c < 10);
                if (step_pulse) begin
                    pulses++;
                    idx = (idx + 1) % 26;
                end
                if (step_pulse && prev) consec++;
                prev = step_pulse;
            end
        end
        check_int("three_press_pulses", pulses, 3);
        check_int("seq_index", idx, 3);
        check_int("no_back_to_back", consec, 0);

        first = 0;
        for (int i = 1; i <= 20 && first == 0; i++) begin
            step(1, 1);
            if (step_pulse) first = i;
        end
        check_int("hold_first_latency", first, 7);
        nrep = 0;
        for (int k = 1; k <= 31; k++) begin
            step(1, 1);
            if (step_pulse) begin
                nrep++;
                offs.push_back(k);
            end
        end
`ifdef BTN_AUTO_REPEAT_EN
        check_int("repeat_count", nrep, 5);
        for (int j = 0; j < 5; j++)
            check_int($sformatf("repeat_offset%0d", j), (j < offs.size()) ? offs[j] : -1, 10 + 5 * j);
`else
        check_int("no_repeat", nrep, 0);
        check_int("no_repeat_offsets", offs.size(), 0);
`endif
        check_bit("hold_level", btn_level, 1'b1);

        step(0, 0);
        step(0, 0);
        check_bit("d1_reset_pulse", step_pulse_d1, 1'b0);
        check_bit("d1_reset_level", btn_level_d1, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            step(1, 1);
            check_bit($sformatf("d1_edge%0d.pulse", i), step_pulse_d1, i == 4);
            check_bit($sformatf("d1_edge%0d.level", i), btn_level_d1, i >= 4);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
